// File: rtl/basic_gate_checker.sv
// Sweep engine for the two-input basic-gate block: it drives all four input vectors, samples the
// seven gate responses after a settle time and reports a sticky error mask, a fail count and pass.
module basic_gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       in_a,
    output logic       in_b,
    input  logic       not_gate_out,
    input  logic       and_gate_out,
    input  logic       nand_gate_out,
    input  logic       or_gate_out,
    input  logic       nor_gate_out,
    input  logic       xor_gate_out,
    input  logic       xnor_gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_vec,
    output logic [2:0] fail_cnt,
    output logic [1:0] vec_idx
);

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [6:0] err_q, err_d;
    logic [2:0] fail_q, fail_d;

    logic       a, b;
    logic [6:0] resp;
    logic [6:0] expected;
    logic [6:0] mismatch;
    logic [2:0] fail_next;

    assign a    = vec_q[1];
    assign b    = vec_q[0];
    assign resp = {xnor_gate_out, xor_gate_out, nor_gate_out, or_gate_out,
                   nand_gate_out, and_gate_out, not_gate_out};

    always_comb begin
        expected  = {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b, ~a};
        mismatch  = resp ^ expected;
        // Saturate at four failing vectors so the count never wraps.
        fail_next = ((|mismatch) && (fail_q != 3'd4)) ? fail_q + 3'd1 : fail_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    cnt_d   = SettleLoad;
                    busy_d  = 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StSample: begin
                err_d  = err_q | mismatch;
                fail_d = fail_next;
                if (vec_q == 2'd3) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (fail_next == 3'd0);
                    vec_d   = 2'd0;
                end else begin
                    state_d = StSettle;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = SettleLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign in_a     = vec_q[1];
    assign in_b     = vec_q[0];
    assign vec_idx  = vec_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_vec  = err_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_basic_gate_checker.sv
// Bench for basic_gate_checker: two instances (settle 2 and 1) driven against a faultable gate
// model, with a per-instance scoreboard of sweep results popped when done is observed.
module tb_basic_gate_checker;

    typedef struct {
        int         start_edge;
        int         done_edge;
        logic [6:0] err;
        logic [2:0] fail;
        logic       pass;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_v;
    int         fault [2];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Bit order: [0] not, [1] and, [2] nand, [3] or, [4] nor, [5] xor, [6] xnor.
    function automatic logic [6:0] golden(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b, ~a};
    endfunction

    // Fault 1: xor stuck at 0. Fault 2: not follows a, nor stuck at 1.
    function automatic logic [6:0] gate_resp(input logic a, input logic b, input int f);
        logic [6:0] r;
        r = golden(a, b);
        if (f == 1) r[5] = 1'b0;
        if (f == 2) begin
            r[0] = a;
            r[4] = 1'b1;
        end
        return r;
    endfunction

    function automatic void exp_result(input int f, output logic [6:0] err, output logic [2:0] fail);
        logic [6:0] d;
        logic [1:0] v;
        err  = '0;
        fail = '0;
        for (int i = 0; i < 4; i++) begin
            v   = 2'(i);
            d   = golden(v[1], v[0]) ^ gate_resp(v[1], v[0], f);
            err = err | d;
            if (d != 7'd0) fail = fail + 3'd1;
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 2 : 1;
        localparam string Pfx = (g == 0) ? "s2" : "s1";

        logic       a, b, busy, done, pass;
        logic [6:0] err_vec, resp;
        logic [2:0] fail_cnt;
        logic [1:0] vec_idx;

        sb_entry_t  sb [$];
        int         ec;
        int         free_at;
        logic       hold_ok;
        logic [6:0] hold_err;
        logic [2:0] hold_fail;
        logic       hold_pass;

        assign resp = gate_resp(a, b, fault[g]);

        basic_gate_checker #(.SETTLE_CYCLES(S)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start_v[g]),
            .in_a         (a),
            .in_b         (b),
            .not_gate_out (resp[0]),
            .and_gate_out (resp[1]),
            .nand_gate_out(resp[2]),
            .or_gate_out  (resp[3]),
            .nor_gate_out (resp[4]),
            .xor_gate_out (resp[5]),
            .xnor_gate_out(resp[6]),
            .busy         (busy),
            .done         (done),
            .pass         (pass),
            .err_vec      (err_vec),
            .fail_cnt     (fail_cnt),
            .vec_idx      (vec_idx)
        );

        // Edge-level model: decides sweep acceptance and pushes expected results.
        initial begin
            sb_entry_t e;
            ec        = 0;
            free_at   = 0;
            hold_ok   = 1'b0;
            hold_err  = '0;
            hold_fail = '0;
            hold_pass = 1'b0;
            forever begin
                @(posedge clk);
                ec++;
                if (rst) begin
                    sb.delete();
                    free_at   = ec + 1;
                    hold_ok   = 1'b1;
                    hold_err  = '0;
                    hold_fail = '0;
                    hold_pass = 1'b0;
                end else if (start_v[g] && ec >= free_at) begin
                    e.start_edge = ec;
                    e.done_edge  = ec + 4 * int'(S + 1);
                    exp_result(fault[g], e.err, e.fail);
                    e.pass = (e.fail == 3'd0);
                    sb.push_back(e);
                    free_at = e.done_edge + 2;
                    hold_ok = 1'b0;
                end
            end
        end

        // Output monitor, sampled on the falling edge.
        initial begin
            logic       exp_busy, exp_done;
            logic [1:0] exp_vec;
            forever begin
                @(negedge clk);
                if (hold_ok) begin
                    check_val({Pfx, ".err_vec"}, int'(err_vec), int'(hold_err));
                    check_val({Pfx, ".fail_cnt"}, int'(fail_cnt), int'(hold_fail));
                    check_val({Pfx, ".pass"}, int'(pass), int'(hold_pass));
                end
                while (sb.size() > 0 && sb[0].done_edge < ec) begin
                    check_val({Pfx, ".done_missing"}, 0, 1);
                    void'(sb.pop_front());
                end
                exp_busy = 1'b0;
                exp_done = 1'b0;
                exp_vec  = 2'd0;
                if (sb.size() > 0 && ec >= sb[0].start_edge) begin
                    if (ec < sb[0].done_edge) begin
                        exp_busy = 1'b1;
                        exp_vec  = 2'((ec - sb[0].start_edge) / int'(S + 1));
                    end
                    if (ec == sb[0].start_edge) begin
                        check_val({Pfx, ".clr_err"}, int'(err_vec), 0);
                        check_val({Pfx, ".clr_fail"}, int'(fail_cnt), 0);
                        check_val({Pfx, ".clr_pass"}, int'(pass), 0);
                    end
                    exp_done = (ec == sb[0].done_edge);
                end
                check_val({Pfx, ".busy"}, int'(busy), int'(exp_busy));
                check_val({Pfx, ".done"}, int'(done), int'(exp_done));
                check_val({Pfx, ".in_ab"}, int'({a, b}), int'(exp_vec));
                check_val({Pfx, ".vec_idx"}, int'(vec_idx), int'(exp_vec));
                if (exp_done) begin
                    check_val({Pfx, ".final_err"}, int'(err_vec), int'(sb[0].err));
                    check_val({Pfx, ".final_fail"}, int'(fail_cnt), int'(sb[0].fail));
                    check_val({Pfx, ".final_pass"}, int'(pass), int'(sb[0].pass));
                    hold_err  = sb[0].err;
                    hold_fail = sb[0].fail;
                    hold_pass = sb[0].pass;
                    hold_ok   = 1'b1;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int g, input int f);
        fault[g]   = f;
        start_v[g] = 1'b1;
        idle(1);
        start_v[g] = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start_v  = 2'b00;
        fault[0] = 0;
        fault[1] = 0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Settle 2: correct, xor stuck-0, not/nor faults.
        pulse(0, 0);
        idle(16);
        pulse(0, 1);
        idle(16);
        pulse(0, 2);
        idle(16);

        // Start held high across several sweeps, including the DONE cycle.
        fault[0]   = 1;
        start_v[0] = 1'b1;
        idle(30);
        start_v[0] = 1'b0;
        idle(16);

        // Reset mid-sweep of a faulty run.
        pulse(0, 2);
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(16);

        // Settle 1: correct, faulty, correct.
        pulse(1, 0);
        idle(12);
        pulse(1, 2);
        idle(12);
        pulse(1, 0);
        idle(12);

        idle(20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
